// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, with sign fix-up and a one-cycle done pulse.
module booth_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   mag_dvs_q, mag_dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // Magnitudes are one bit wider so the most negative operand is representable.
    logic [WIDTH:0]   dvd_ext, dvs_ext, mag_dvd, mag_dvs;
    logic [WIDTH:0]   r_shift, r_sub, rem_neg;
    logic [WIDTH-1:0] q_shift;

    assign dvd_ext = {dvd_q[WIDTH-1], dvd_q};
    assign dvs_ext = {dvs_q[WIDTH-1], dvs_q};
    assign mag_dvd = dvd_q[WIDTH-1] ? ((WIDTH+1)'(0) - dvd_ext) : dvd_ext;
    assign mag_dvs = dvs_q[WIDTH-1] ? ((WIDTH+1)'(0) - dvs_ext) : dvs_ext;
    assign r_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign q_shift = {quo_q[WIDTH-2:0], 1'b0};
    assign r_sub   = r_shift - mag_dvs_q;
    assign rem_neg = (WIDTH+1)'(0) - rem_q;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        mag_dvs_d   = mag_dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    dbz_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_quo_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                neg_rem_d = dvd_q[WIDTH-1];
                quo_d     = mag_dvd[WIDTH-1:0];
                mag_dvs_d = mag_dvs;
                rem_d     = '0;
                cnt_d     = '0;
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (r_shift >= mag_dvs_q) begin
                    rem_d = r_sub;
                    quo_d = q_shift | WIDTH'(1);
                end else begin
                    rem_d = r_shift;
                    quo_d = q_shift;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
                remainder_d = neg_rem_q ? rem_neg[WIDTH-1:0] : rem_q[WIDTH-1:0];
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            mag_dvs_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            mag_dvs_q   <= mag_dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
